// File: rtl/truth_table_input_conditioner.sv
// Input conditioner for the 3-input truth table: synchronises and debounces three raw
// switch levels, then commits them as one coherent {a,b,c} word after a group hold-off.
module truth_table_input_conditioner #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 16,
    parameter int HOLDOFF_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sw_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       abc_strobe,
    output logic       busy
);

    localparam int CNT_W  = (STABLE_CYCLES  > 1) ? $clog2(STABLE_CYCLES)  : 1;
    localparam int HCNT_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [HCNT_W-1:0] HCNT_MAX = HCNT_W'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Synchroniser chain: row 0 samples the pin, the last row is the synced value.
    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic [2:0]                  sync;

    logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]            deb_q, deb_d;
    logic [2:0]            deb_prev_q;

    state_t            state_q, state_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic [2:0]        abc_q, abc_d;
    logic              strobe_q, strobe_d;
    logic              busy_q, busy_d;

    assign sync = sync_q[SYNC_STAGES-1];

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw_in};
        end
    end

    // Per-bit debounce: deb flips only after STABLE_CYCLES consecutive disagreeing samples.
    always_comb begin
        // NOTE: defaults first so no path through this block leaves a latch.
        cnt_d = cnt_q;
        deb_d = deb_q;
        for (int i = 0; i < 3; i++) begin
            if (sync[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                deb_d[i] = sync[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
        end
    end

    // Group FSM: wait until the debounced word has been quiet for HOLDOFF_CYCLES, then commit.
    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        abc_d    = abc_q;
        strobe_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (deb_q != abc_q) begin
                    state_d = SETTLE;
                    hcnt_d  = '0;
                end
            end
            SETTLE: begin
                if (deb_q != deb_prev_q) begin
                    hcnt_d = '0;
                end else if (hcnt_q == HCNT_MAX) begin
                    state_d = COMMIT;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                // A word that drifted back to the committed value is dropped silently.
                if (deb_q != abc_q) begin
                    abc_d    = deb_q;
                    strobe_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            hcnt_q   <= '0;
            abc_q    <= '0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            abc_q    <= abc_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
        end
    end

    assign a          = abc_q[2];
    assign b          = abc_q[1];
    assign c          = abc_q[0];
    assign abc_strobe = strobe_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_truth_table_input_conditioner.sv
// Directed bench for truth_table_input_conditioner: a vector table of clean word changes plus
// hand-written reset, glitch, skew, revert and async-reset sequences.
module tb_truth_table_input_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] sw_in;
    logic [2:0] sw_r;
    logic       a, b, c, abc_strobe, busy;
    logic       a_r, b_r, c_r, strobe_r, busy_r;
    logic [2:0] abc;
    logic [2:0] abc_r;

    int n_vec  = 0;
    int n_fail = 0;
    int edge_n = 0;

    assign abc   = {a, b, c};
    assign abc_r = {a_r, b_r, c_r};

    always #5 clk = ~clk;

    truth_table_input_conditioner dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_in      (sw_in),
        .a          (a),
        .b          (b),
        .c          (c),
        .abc_strobe (abc_strobe),
        .busy       (busy)
    );

    // Long hold-off so a debounced change can revert before the group commits.
    truth_table_input_conditioner #(.HOLDOFF_CYCLES(32)) dut_r (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_in      (sw_r),
        .a          (a_r),
        .b          (b_r),
        .c          (c_r),
        .abc_strobe (strobe_r),
        .busy       (busy_r)
    );

    typedef struct {
        logic [2:0] sw;
        logic [2:0] prev;
        logic [2:0] exp;
        int         strobes;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    initial begin
        int strobes;
        int strobes_r;
        logic busy_seen, abc_bad, saw_010;

        vecs[0] = '{sw: 3'b000, prev: 3'b111, exp: 3'b000, strobes: 1};
        vecs[1] = '{sw: 3'b010, prev: 3'b000, exp: 3'b010, strobes: 1};
        vecs[2] = '{sw: 3'b101, prev: 3'b010, exp: 3'b101, strobes: 1};
        vecs[3] = '{sw: 3'b101, prev: 3'b101, exp: 3'b101, strobes: 0};
        vecs[4] = '{sw: 3'b110, prev: 3'b101, exp: 3'b110, strobes: 1};
        vecs[5] = '{sw: 3'b001, prev: 3'b110, exp: 3'b001, strobes: 1};
        vecs[6] = '{sw: 3'b000, prev: 3'b001, exp: 3'b000, strobes: 1};

        // Reset with inputs high, then release: word appears on edge 28.
        rst_n = 1'b0;
        sw_in = 3'b111;
        sw_r  = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_abc", 8'(abc), 8'h0);
        check("rst_strobe", 8'(abc_strobe), 8'h0);
        check("rst_busy", 8'(busy), 8'h0);
        rst_n  = 1'b1;
        edge_n = 0;
        tick();
        check("post_rst_outputs", 8'({abc, abc_strobe, busy}), 8'h0);
        while (edge_n < 27) tick();
        check("rst_abc_e27", 8'(abc), 8'h0);
        tick();
        check("rst_abc_e28", 8'(abc), 8'h7);
        check("rst_strobe_e28", 8'(abc_strobe), 8'h1);
        tick();
        check("rst_strobe_e29", 8'(abc_strobe), 8'h0);
        check("rst_busy_e29", 8'(busy), 8'h0);
        repeat (5) tick();

        // Table: each clean change commits on edge 28 with exactly one strobe.
        for (int v = 0; v < 7; v++) begin
            sw_in   = vecs[v].sw;
            edge_n  = 0;
            strobes = 0;
            for (int e = 1; e <= 40; e++) begin
                tick();
                if (abc_strobe) strobes++;
                if (e == 27) check($sformatf("vec%0d_abc_e27", v), 8'(abc), 8'(vecs[v].prev));
                if (e == 28) begin
                    check($sformatf("vec%0d_abc_e28", v), 8'(abc), 8'(vecs[v].exp));
                    check($sformatf("vec%0d_strobe_e28", v), 8'(abc_strobe),
                          8'(vecs[v].strobes));
                end
            end
            check($sformatf("vec%0d_strobe_count", v), 8'(strobes), 8'(vecs[v].strobes));
        end

        // Glitch: 10-cycle pulse on sw_in[0] never reaches the outputs.
        sw_in     = 3'b001;
        edge_n    = 0;
        strobes   = 0;
        busy_seen = 1'b0;
        abc_bad   = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (e == 10) sw_in = 3'b000;
            if (abc_strobe) strobes++;
            if (busy) busy_seen = 1'b1;
            if (abc != 3'b000) abc_bad = 1'b1;
        end
        check("glitch_strobe", 8'(strobes), 8'h0);
        check("glitch_busy", 8'(busy_seen), 8'h0);
        check("glitch_abc", 8'(abc_bad), 8'h0);

        // Skew: b rises at edge 1, a at edge 6; a single commit of 110 on edge 33.
        sw_in   = 3'b010;
        edge_n  = 0;
        strobes = 0;
        saw_010 = 1'b0;
        for (int e = 1; e <= 45; e++) begin
            tick();
            if (e == 5) sw_in = 3'b110;
            if (abc_strobe) strobes++;
            if (abc == 3'b010) saw_010 = 1'b1;
            if (e == 19) check("skew_busy_e19", 8'(busy), 8'h1);
            if (e == 32) check("skew_abc_e32", 8'(abc), 8'h0);
            if (e == 33) check("skew_abc_e33", 8'(abc), 8'h6);
        end
        check("skew_strobe_count", 8'(strobes), 8'h1);
        check("skew_no_010", 8'(saw_010), 8'h0);

        // Async reset in the middle of SETTLE.
        sw_in  = 3'b010;
        edge_n = 0;
        repeat (40) tick();
        check("pre_arst_abc", 8'(abc), 8'h2);
        sw_in  = 3'b000;
        edge_n = 0;
        repeat (22) tick();
        check("pre_arst_busy", 8'(busy), 8'h1);
        check("pre_arst_abc_held", 8'(abc), 8'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_abc", 8'(abc), 8'h0);
        check("arst_busy", 8'(busy), 8'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Revert on the long hold-off instance: deb[2] 1 on edge 18, 0 on edge 39, no commit.
        sw_r      = 3'b100;
        edge_n    = 0;
        strobes_r = 0;
        abc_bad   = 1'b0;
        for (int e = 1; e <= 90; e++) begin
            tick();
            if (e == 21) sw_r = 3'b000;
            if (strobe_r) strobes_r++;
            if (abc_r != 3'b000) abc_bad = 1'b1;
            if (e == 18) check("rev_busy_e18", 8'(busy_r), 8'h0);
            if (e == 19) check("rev_busy_e19", 8'(busy_r), 8'h1);
            if (e == 60) check("rev_busy_e60", 8'(busy_r), 8'h1);
            if (e == 72) check("rev_busy_e72", 8'(busy_r), 8'h1);
            if (e == 73) check("rev_busy_e73", 8'(busy_r), 8'h0);
        end
        check("rev_strobe", 8'(strobes_r), 8'h0);
        check("rev_abc", 8'(abc_bad), 8'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
